// File: rtl/sobel_window_gen.sv
// sobel_window_gen: producer side of the Sobel 3x3 matrix interface.
// Accepts a raster-order pixel stream, keeps two line buffers and a 3x3
// shift window, and presents one registered 3x3 window per interior pixel.
//
// Optional build macro: WINDOW_SIDEBAND_EN adds win_sol_o / win_eol_o /
// win_eof_o, registered alongside the window.
//
// Handshake (both sides): a transfer happens on a rising clk_i edge where
// valid and ready are both high. A source holds its data and valid stable
// until that edge. pixel_ready_o = !win_valid_o || win_ready_i, so a pixel
// is only taken when the single output stage is empty or being drained
// in the same cycle.
module sobel_window_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PIXEL_WIDTH-1:0] pixel_i,
  input  logic                   pixel_valid_i,
  output logic                   pixel_ready_o,
  input  logic                   sof_i,
  output logic [PIXEL_WIDTH-1:0] win_p0_o,
  output logic [PIXEL_WIDTH-1:0] win_p1_o,
  output logic [PIXEL_WIDTH-1:0] win_p2_o,
  output logic [PIXEL_WIDTH-1:0] win_p3_o,
  output logic [PIXEL_WIDTH-1:0] win_p4_o,
  output logic [PIXEL_WIDTH-1:0] win_p5_o,
  output logic [PIXEL_WIDTH-1:0] win_p6_o,
  output logic [PIXEL_WIDTH-1:0] win_p7_o,
  output logic [PIXEL_WIDTH-1:0] win_p8_o,
`ifdef WINDOW_SIDEBAND_EN
  output logic                   win_sol_o,
  output logic                   win_eol_o,
  output logic                   win_eof_o,
`endif
  output logic                   win_valid_o,
  input  logic                   win_ready_i
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Position the current pixel is treated as (sof_i forces 0,0).
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // Line buffers: lb1 holds the previous line, lb0 the one before it.
  logic [PIXEL_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb0_rd;
  logic [PIXEL_WIDTH-1:0] lb1_rd;

  // Shift window, row-major: index 0 top-left, 8 bottom-right.
  logic [PIXEL_WIDTH-1:0] sw_q [9];
  logic [PIXEL_WIDTH-1:0] sw_d [9];
  logic [PIXEL_WIDTH-1:0] sw_base [9];

  // Output stage.
  logic [PIXEL_WIDTH-1:0] win_q [9];
  logic [PIXEL_WIDTH-1:0] win_d [9];
  logic                   valid_q, valid_d;

`ifdef WINDOW_SIDEBAND_EN
  logic sol_q, sol_d;
  logic eol_q, eol_d;
  logic eof_q, eof_d;
`endif

  logic accept;
  logic emit;

  assign pixel_ready_o = !valid_q || win_ready_i;
  assign accept        = pixel_valid_i && pixel_ready_o;

  assign cur_col = sof_i ? '0 : col_q;
  assign cur_row = sof_i ? '0 : row_q;

  // Only interior centres produce a window; no wrap-around across lines.
  assign emit = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

  assign lb0_rd = lb0_q[cur_col];
  assign lb1_rd = lb1_q[cur_col];

  // Next raster position after an accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = cur_row + RW'(1);
        end
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // Raster position register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers shift one line down at the accepted column; no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_q[cur_col] <= lb1_rd;
      lb1_q[cur_col] <= pixel_i;
    end
  end

  // Shift window: start of frame discards old columns, then shift left and
  // append the new right column (r-2, r-1, r).
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      sw_base[i] = sof_i ? '0 : sw_q[i];
      sw_d[i]    = sw_q[i];
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sw_d[r*3 + 0] = sw_base[r*3 + 1];
        sw_d[r*3 + 1] = sw_base[r*3 + 2];
      end
      sw_d[2] = lb0_rd;
      sw_d[5] = lb1_rd;
      sw_d[8] = pixel_i;
    end
  end

  // Shift window register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 9; i++) begin
        sw_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        sw_q[i] <= sw_d[i];
      end
    end
  end

  // Output stage: load on a window-producing accept, otherwise drain on
  // win_ready_i; data holds whenever nothing new is loaded.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
`ifdef WINDOW_SIDEBAND_EN
    sol_d = sol_q;
    eol_d = eol_q;
    eof_d = eof_q;
`endif
    if (emit) begin
      valid_d = 1'b1;
      for (int i = 0; i < 9; i++) begin
        win_d[i] = sw_d[i];
      end
`ifdef WINDOW_SIDEBAND_EN
      // Centre is one column left of the accepted pixel.
      sol_d = (cur_col == COL_TWO);
      eol_d = (cur_col == COL_LAST);
      eof_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
`endif
    end else if (win_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output stage register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
`ifdef WINDOW_SIDEBAND_EN
      sol_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
`ifdef WINDOW_SIDEBAND_EN
      sol_q <= sol_d;
      eol_q <= eol_d;
      eof_q <= eof_d;
`endif
    end
  end

  assign win_valid_o = valid_q;
  assign win_p0_o    = win_q[0];
  assign win_p1_o    = win_q[1];
  assign win_p2_o    = win_q[2];
  assign win_p3_o    = win_q[3];
  assign win_p4_o    = win_q[4];
  assign win_p5_o    = win_q[5];
  assign win_p6_o    = win_q[6];
  assign win_p7_o    = win_q[7];
  assign win_p8_o    = win_q[8];
`ifdef WINDOW_SIDEBAND_EN
  assign win_sol_o   = sol_q;
  assign win_eol_o   = eol_q;
  assign win_eof_o   = eof_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen on a 4x4 image. Reference model keeps the
// current frame as a 2-D array indexed by raster position; every window is
// cut straight out of that array.
module tb_sobel_window_gen;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef WINDOW_SIDEBAND_EN
  localparam int SB = 3;
`else
  localparam int SB = 0;
`endif
  localparam int XW = 9 * PW + SB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic [PW-1:0] pixel_i = '0;
  logic          pixel_valid_i = 1'b0;
  logic          pixel_ready_o;
  logic          sof_i = 1'b0;
  logic [PW-1:0] win_p0_o, win_p1_o, win_p2_o, win_p3_o, win_p4_o;
  logic [PW-1:0] win_p5_o, win_p6_o, win_p7_o, win_p8_o;
  logic          win_valid_o;
  logic          win_ready_i = 1'b1;
`ifdef WINDOW_SIDEBAND_EN
  logic          win_sol_o, win_eol_o, win_eof_o;
`endif

  sobel_window_gen #(
    .PIXEL_WIDTH(PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pixel_i      (pixel_i),
    .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o),
    .sof_i        (sof_i),
    .win_p0_o     (win_p0_o),
    .win_p1_o     (win_p1_o),
    .win_p2_o     (win_p2_o),
    .win_p3_o     (win_p3_o),
    .win_p4_o     (win_p4_o),
    .win_p5_o     (win_p5_o),
    .win_p6_o     (win_p6_o),
    .win_p7_o     (win_p7_o),
    .win_p8_o     (win_p8_o),
`ifdef WINDOW_SIDEBAND_EN
    .win_sol_o    (win_sol_o),
    .win_eol_o    (win_eol_o),
    .win_eof_o    (win_eof_o),
`endif
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i)
  );

  // ---------------- scoreboard state ----------------
  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] got_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int win_cnt = 0;

  logic [PW-1:0] img [H][W];
  int mr = 0;
  int mc = 0;

  int stall_hold = 0;
  bit arm_stall = 1'b0;
  bit rand_bp = 1'b0;
  bit rand_gap = 1'b0;

  bit            prev_stall = 1'b0;
  logic [XW-1:0] prev_out;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [XW-1:0] dut_out();
    logic [XW-1:0] v;
`ifdef WINDOW_SIDEBAND_EN
    v = {win_p0_o, win_p1_o, win_p2_o, win_p3_o, win_p4_o, win_p5_o,
         win_p6_o, win_p7_o, win_p8_o, win_sol_o, win_eol_o, win_eof_o};
`else
    v = {win_p0_o, win_p1_o, win_p2_o, win_p3_o, win_p4_o, win_p5_o,
         win_p6_o, win_p7_o, win_p8_o};
`endif
    return v;
  endfunction

  // Window whose bottom-right pixel is (r,c), i.e. centred on (r-1,c-1).
  function automatic logic [XW-1:0] model_window(input int r, input int c);
    logic [9*PW-1:0] px;
    logic [XW-1:0]   v;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px[(8 - (i*3 + j))*PW +: PW] = img[r-2+i][c-2+j];
      end
    end
`ifdef WINDOW_SIDEBAND_EN
    v = {px, (c-1 == 1), (c-1 == W-2), ((r-1 == H-2) && (c-1 == W-2))};
`else
    v = px;
`endif
    return v;
  endfunction

  // Record an accepted pixel; returns 1 if it completes an interior window.
  function automatic bit model_accept(input logic [PW-1:0] pix, input bit sof);
    int r;
    int c;
    bit em;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    r = mr;
    c = mc;
    img[r][c] = pix;
    em = (r >= 2) && (c >= 2);
    if (em) exp_q.push_back(model_window(r, c));
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
    return em;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the pixel is taken.
  task automatic send_pixel(input logic [PW-1:0] pix, input bit sof);
    bit acc;
    bit em;
    if (rand_gap && $urandom_range(0, 3) == 0) begin
      pixel_valid_i = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    pixel_i = pix;
    sof_i = sof;
    pixel_valid_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = pixel_ready_o;
      em = 1'b0;
      if (acc) em = model_accept(pix, sof);
      @(posedge clk);
      #1;
      if (acc) begin
        pixel_valid_i = 1'b0;
        sof_i = 1'b0;
        if (em) begin
          check("latency_valid", win_valid_o, 1'b1);
          check("latency_p8", win_p8_o, pix);
        end
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL accept_timeout: pixel %0h never accepted", pix);
    pixel_valid_i = 1'b0;
    sof_i = 1'b0;
  endtask

  task automatic send_frame(input bit random_px, input bit sof_first);
    logic [PW-1:0] p;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = random_px ? PW'($urandom) : PW'(r*16 + c);
        send_pixel(p, sof_first && r == 0 && c == 0);
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    pixel_valid_i = 1'b0;
    sof_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
  endtask

  // ---------------- consumer backpressure ----------------
  always @(posedge clk) begin
    #1;
    if (arm_stall && win_valid_o) begin
      stall_hold = 5;
      arm_stall = 1'b0;
    end
    if (stall_hold > 0) begin
      win_ready_i = 1'b0;
      stall_hold--;
    end else begin
      win_ready_i = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_i) begin
      check("pixel_ready", pixel_ready_o, !win_valid_o || win_ready_i);
      if (prev_stall) check("stall_hold_outputs", dut_out(), prev_out);
      if (win_valid_o && win_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_window: got %0h expected none", dut_out());
        end else begin
          check("window", dut_out(), exp_q.pop_front());
        end
        got_q.push_back(dut_out());
        win_cnt++;
      end
      prev_stall = win_valid_o && !win_ready_i;
      prev_out = dut_out();
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9*PW-1:0] first_win;
    first_win = 72'h00_01_02_10_11_12_20_21_22;

    do_reset();
    check("reset_valid", win_valid_o, 1'b0);
    check("reset_window", dut_out(), '0);
    check("reset_ready", pixel_ready_o, 1'b1);

    // Plain frame, continuous flow.
    win_cnt = 0;
    got_q.delete();
    send_frame(1'b0, 1'b0);
    drain();
    check("t1_count", win_cnt, 4);
    if (got_q.size() == 4) begin
      check("t1_first_window", got_q[0][XW-1 -: 9*PW], first_win);
      check("t1_wrap_p0", got_q[1][XW-1 -: PW], 8'h01);
      check("t1_wrap_p8", got_q[1][SB +: PW], 8'h23);
      check("t1_after_wrap_p8", got_q[2][SB +: PW], 8'h32);
      check("t1_last_p8", got_q[3][SB +: PW], 8'h33);
`ifdef WINDOW_SIDEBAND_EN
      check("sb_w0", got_q[0][2:0], 3'b100);
      check("sb_w1", got_q[1][2:0], 3'b010);
      check("sb_w2", got_q[2][2:0], 3'b100);
      check("sb_w3", got_q[3][2:0], 3'b011);
`endif
    end

    // Backpressure for 5 cycles on the first window.
    win_cnt = 0;
    arm_stall = 1'b1;
    send_frame(1'b0, 1'b1);
    drain();
    check("t2_count", win_cnt, 4);

    // Mid-frame resync: partial frame up to (2,0), sof on the (2,1) pixel.
    win_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 1) begin
          send_pixel(8'h21, 1'b1);
          break;
        end
        send_pixel(PW'(r*16 + c), 1'b0);
      end
    end
    send_frame(1'b0, 1'b1);
    drain();
    check("t3_count", win_cnt, 4);

    // Reset while a window is pending.
    for (int i = 0; i < 11; i++) begin
      send_pixel(PW'((i / W)*16 + (i % W)), i == 0);
    end
    check("t4_pending_valid", win_valid_o, 1'b1);
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t4_reset_valid", win_valid_o, 1'b0);
    check("t4_reset_window", dut_out(), '0);
    rst_i = 1'b0;
    mr = 0;
    mc = 0;
    win_cnt = 0;
    send_frame(1'b0, 1'b0);
    drain();
    check("t4_count", win_cnt, 4);

    // Random pixels, random gaps, random backpressure.
    win_cnt = 0;
    rand_bp = 1'b1;
    rand_gap = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b1);
    drain();
    rand_bp = 1'b0;
    rand_gap = 1'b0;
    check("t5_count", win_cnt, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
